// File: rtl/fetch_ctrl.sv
`default_nettype none
// ============================================================================
// fetch_ctrl : instruction-fetch controller with one outstanding imem request
//              and an IF/ID stage that honours decode stall and branch flush.
// Rev 1.0
// ============================================================================
module fetch_ctrl #(
  parameter logic [31:0] INIT_ADDR = 32'h0000_3000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] pc_in,
  output logic        pc_we,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        stall,
  input  logic        flush,
  output logic        ifid_valid,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_pc,
  output logic [31:0] ifid_pc_plus4
);

  localparam logic [1:0] S_REQ  = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;
  localparam logic [1:0] S_DROP = 2'd3;

  logic [1:0]  state;
  logic [1:0]  state_next;
  logic [31:0] req_pc;
  logic [31:0] hold_instr;
  logic [31:0] hold_pc;
  logic        ifid_free;
  logic        accept;
  logic        load_rsp;
  logic        load_hold;
  logic        hold_we;

  assign imem_req_addr = pc_in & 32'hFFFF_FFFC;
  assign ifid_free     = !ifid_valid || !stall;
  assign accept        = imem_req_valid && imem_req_ready;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= S_REQ;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (flush) begin
      // A request still in flight must have its response swallowed later.
      state_next = ((state == S_WAIT || state == S_DROP) && !imem_rsp_valid) ? S_DROP : S_REQ;
    end else begin
      case (state)
        S_REQ:   if (accept)         state_next = S_WAIT;
        S_WAIT:  if (imem_rsp_valid) state_next = ifid_free ? S_REQ : S_HOLD;
        S_HOLD:  if (!stall)         state_next = S_REQ;
        S_DROP:  if (imem_rsp_valid) state_next = S_REQ;
        default:                     state_next = S_REQ;
      endcase
    end
  end

  always_comb begin
    imem_req_valid = reset && (state == S_REQ) && !flush;
    pc_we          = reset && (flush || ((state == S_REQ) && imem_req_ready));
    load_rsp       = !flush && (state == S_WAIT) && imem_rsp_valid && ifid_free;
    hold_we        = !flush && (state == S_WAIT) && imem_rsp_valid && !ifid_free;
    load_hold      = !flush && (state == S_HOLD) && !stall;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      req_pc     <= INIT_ADDR;
      hold_instr <= NOP_INSTR;
      hold_pc    <= INIT_ADDR;
    end else begin
      if (accept) req_pc <= imem_req_addr;
      if (flush) begin
        hold_instr <= NOP_INSTR;
      end else if (hold_we) begin
        hold_instr <= imem_rsp_data;
        hold_pc    <= req_pc;
      end
    end
  end

  // Stalled IF/ID keeps its contents untouched; pc fields survive a consume.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ifid_valid    <= 1'b0;
      ifid_instr    <= NOP_INSTR;
      ifid_pc       <= INIT_ADDR;
      ifid_pc_plus4 <= INIT_ADDR + 32'd4;
    end else if (flush) begin
      ifid_valid <= 1'b0;
      ifid_instr <= NOP_INSTR;
    end else if (load_rsp) begin
      ifid_valid    <= 1'b1;
      ifid_instr    <= imem_rsp_data;
      ifid_pc       <= req_pc;
      ifid_pc_plus4 <= req_pc + 32'd4;
    end else if (load_hold) begin
      ifid_valid    <= 1'b1;
      ifid_instr    <= hold_instr;
      ifid_pc       <= hold_pc;
      ifid_pc_plus4 <= hold_pc + 32'd4;
    end else if (ifid_valid && !stall) begin
      ifid_valid <= 1'b0;
      ifid_instr <= NOP_INSTR;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// tb_fetch_ctrl : randomized scoreboard bench for fetch_ctrl.
// Rev 1.0
// ============================================================================
module tb_fetch_ctrl;

  localparam logic [31:0] INIT_ADDR = 32'h0000_3000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] pc_in = INIT_ADDR;
  logic        imem_req_ready = 1'b0;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = 32'h0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic        pc_we;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        ifid_valid;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pc;
  logic [31:0] ifid_pc_plus4;

  fetch_ctrl #(.INIT_ADDR(INIT_ADDR), .NOP_INSTR(NOP_INSTR)) dut (
    .clock(clock), .reset(reset), .pc_in(pc_in), .pc_we(pc_we),
    .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
    .imem_req_ready(imem_req_ready), .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data), .stall(stall), .flush(flush),
    .ifid_valid(ifid_valid), .ifid_instr(ifid_instr), .ifid_pc(ifid_pc),
    .ifid_pc_plus4(ifid_pc_plus4)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_t;

  fetch_t      exp_q[$];      // live fetched words, oldest first
  int          n_tests = 0;
  int          n_fail  = 0;
  int          returned = 0;  // live words sitting in IF/ID plus hold
  bit          pend = 0;      // imem request in flight
  bit          pend_live = 0; // in-flight response still wanted
  int          pend_cnt = 0;
  logic [31:0] pend_data = 32'h0;
  logic [31:0] pc_next = INIT_ADDR;
  logic [31:0] next_target = 32'h0000_4000;
  bit          mon_en = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle: drive at the falling edge, check combinational outputs,
  // then advance the reference model to what the next rising edge produces.
  task automatic step(input bit st, input bit fl, input bit rdy, input int k,
                      input logic [31:0] data);
    bit rsp;
    bit exp_req;
    bit exp_we;
    int old;
    @(negedge clock);
    chk("ifid_valid", {31'b0, ifid_valid}, (returned > 0) ? 32'd1 : 32'd0);
    pc_in = pc_next;
    stall = st;
    flush = fl;
    imem_req_ready = rdy;
    rsp = 0;
    if (pend) begin
      pend_cnt--;
      if (pend_cnt == 0) rsp = 1;
    end
    imem_rsp_valid = rsp;
    imem_rsp_data  = rsp ? pend_data : $urandom;
    #1;
    exp_req = !fl && !pend && (returned <= 1);
    exp_we  = fl || (exp_req && rdy);
    chk("req_valid", {31'b0, imem_req_valid}, {31'b0, exp_req});
    chk("pc_we", {31'b0, pc_we}, {31'b0, exp_we});
    if (exp_req) chk("req_addr", imem_req_addr, pc_in & 32'hFFFF_FFFC);
    old = returned;
    if (fl) begin
      returned = 0;
      if (rsp) pend = 0;
      else if (pend) pend_live = 0;
    end else begin
      returned = old - ((old > 0 && !st) ? 1 : 0);
      if (rsp) begin
        pend = 0;
        if (pend_live) returned++;
      end
    end
    if (exp_req && rdy) begin
      pend      = 1;
      pend_live = 1;
      pend_cnt  = k;
      pend_data = data;
      exp_q.push_back({pc_in & 32'hFFFF_FFFC, data});
    end
    if (exp_we) pc_next = fl ? next_target : pc_in + 32'd4;
  endtask

  // Monitor: compare IF/ID against the oldest live word; retire on consume.
  initial begin
    forever begin
      @(negedge clock);
      #2;
      if (mon_en) begin
        if (ifid_valid) begin
          chk("ifid_has_expected", (exp_q.size() != 0) ? 32'd1 : 32'd0, 32'd1);
          if (exp_q.size() != 0) begin
            chk("ifid_instr", ifid_instr, exp_q[0].instr);
            chk("ifid_pc", ifid_pc, exp_q[0].pc);
            chk("ifid_pc_plus4", ifid_pc_plus4, exp_q[0].pc + 32'd4);
          end
        end else begin
          chk("ifid_nop", ifid_instr, NOP_INSTR);
        end
        if (flush) exp_q.delete();
        else if (ifid_valid && !stall && exp_q.size() != 0) void'(exp_q.pop_front());
      end
    end
  end

  task automatic check_reset_values();
    chk("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
    chk("rst_pc_we", {31'b0, pc_we}, 32'd0);
    chk("rst_ifid_valid", {31'b0, ifid_valid}, 32'd0);
    chk("rst_ifid_instr", ifid_instr, NOP_INSTR);
    chk("rst_ifid_pc", ifid_pc, INIT_ADDR);
    chk("rst_ifid_pc_plus4", ifid_pc_plus4, INIT_ADDR + 32'd4);
  endtask

  task automatic random_steps(input int n);
    logic [31:0] r;
    for (int i = 0; i < n; i++) begin
      r = $urandom;
      next_target = (r[3:0] == 4'd0) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFC);
      step(($urandom_range(0, 9) < 3), ($urandom_range(0, 24) < 2),
           ($urandom_range(0, 9) < 7), $urandom_range(1, 4), $urandom);
    end
  endtask

  task automatic do_reset_model();
    mon_en    = 0;
    exp_q.delete();
    returned  = 0;
    pend      = 0;
    pend_live = 0;
    pc_next   = INIT_ADDR;
  endtask

  initial begin
    // Reset state, with ready and flush asserted to show they are masked.
    imem_req_ready = 1'b1;
    flush = 1'b1;
    repeat (2) @(negedge clock);
    #1 check_reset_values();
    flush = 1'b0;
    imem_req_ready = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    mon_en = 1;

    // First fetch at the reset vector, k=1.
    step(0, 0, 1, 1, 32'h2408_0001);
    step(1, 0, 0, 1, 32'h0);
    // IF/ID full and stalled; imem not ready for 3 cycles.
    repeat (3) step(1, 0, 0, 1, 32'h0);
    // Response arrives while stalled -> parked in hold buffer.
    step(1, 0, 1, 2, 32'h1111_2222);
    repeat (4) step(1, 0, 0, 1, 32'h0);
    step(0, 0, 0, 1, 32'h0);
    step(0, 0, 0, 1, 32'h0);
    // Flush while waiting on a k=3 response; redirect to the top word.
    step(0, 0, 1, 3, 32'h3333_4444);
    step(0, 0, 0, 1, 32'h0);
    next_target = 32'hFFFF_FFFC;
    step(0, 1, 0, 1, 32'h0);
    step(0, 0, 0, 1, 32'h0);
    // Fetch at the top of memory; pc_plus4 wraps to zero.
    step(0, 0, 1, 1, 32'h5555_6666);
    step(1, 0, 0, 1, 32'h0);
    step(1, 0, 0, 1, 32'h0);
    // Flush and stall together with IF/ID full.
    next_target = 32'h0000_8000;
    step(1, 1, 0, 1, 32'h0);
    step(1, 0, 0, 1, 32'h0);

    random_steps(2000);

    // Quiesce, then load IF/ID and start a k=3 request before an async reset.
    for (int i = 0; i < 40 && (pend || returned != 0); i++) step(0, 0, 0, 1, 32'h0);
    chk("quiesce", (pend || returned != 0) ? 32'd1 : 32'd0, 32'd0);
    step(0, 0, 1, 1, 32'h7777_8888);
    step(1, 0, 0, 1, 32'h0);
    step(1, 0, 1, 3, 32'h9999_AAAA);
    step(1, 0, 0, 1, 32'h0);
    #2 reset = 1'b0;
    do_reset_model();
    #1 check_reset_values();
    @(negedge clock);
    flush = 1'b0;
    stall = 1'b0;
    imem_rsp_valid = 1'b0;
    pc_in = INIT_ADDR;
    reset = 1'b1;
    mon_en = 1;

    random_steps(500);

    // Drain without new requests.
    for (int i = 0; i < 40 && (pend || returned != 0); i++) step(0, 0, 0, 1, 32'h0);
    step(0, 0, 0, 1, 32'h0);
    #3;
    chk("drain_pending", (pend || returned != 0) ? 32'd1 : 32'd0, 32'd0);
    chk("drain_queue", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
